execute_writeback_stage: RTL and testbench

//  Consumes the 32-bit instruction registered by the fetch stage (instruction_EX) and executes it.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/regfile_32x32.sv | 33 +++
 rtl/execute_writeback_stage.sv | 121 ++++++++++++
 tb/tb_execute_writeback_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the integer execute/writeback datapath.
// Holds opcodes, ALU operation encodings and the decoded-instruction bundle.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef struct packed {
        alu_op_e           alu_op;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic              we;
        logic              illegal;
    } decoded_t;

    // funct3 -> ALU op; alt selects SUB/SRA over ADD/SRL.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: two async read ports, one debug read, one sync write.
// x0 always reads zero; reset clears every entry synchronously.
module regfile_32x32
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] dbg_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
    assign dbg_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/execute_writeback_stage.sv
// RV32I integer-subset execute stage feeding a single writeback register.
// WB result is forwarded into EX so dependent instructions never stall.
module execute_writeback_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction_EX,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] dbg_data_o
);

    decoded_t        dec;
    logic [XLEN-1:0] rf_rd1, rf_rd2, op_a, op_b, rs2_val, alu_res;
    logic [4:0]      shamt;
    logic            wb_we_q, illegal_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       f7_zero, f7_alt;

    assign opcode  = instruction_EX[6:0];
    assign f3      = instruction_EX[14:12];
    assign f7      = instruction_EX[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.rd      = instruction_EX[11:7];
        dec.rs1     = instruction_EX[19:15];
        dec.rs2     = instruction_EX[24:20];
        dec.imm     = {{20{instruction_EX[31]}}, instruction_EX[31:20]};
        case (opcode)
            OPC_OP: begin
                dec.alu_op  = alu_from_f3(f3, instruction_EX[30]);
                dec.illegal = !(f7_zero || (f7_alt && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                dec.use_imm = 1'b1;
                // Only shifts interpret funct7; other OP-IMM ops carry immediate bits there.
                dec.alu_op  = alu_from_f3(f3, (f3 == 3'd5) && instruction_EX[30]);
                dec.illegal = ((f3 == 3'd1) && !f7_zero) ||
                              ((f3 == 3'd5) && !(f7_zero || f7_alt));
            end
            OPC_LUI: begin
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_PASS_B;
                dec.imm     = {instruction_EX[31:12], 12'h000};
            end
            default: dec.illegal = (instruction_EX != 32'h0);
        endcase
        dec.we = !dec.illegal && (instruction_EX != 32'h0) && (dec.rd != 5'd0);
    end

    regfile_32x32 u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra1_i      (dec.rs1),
        .ra2_i      (dec.rs2),
        .dbg_addr_i (dbg_addr_i),
        .rd1_o      (rf_rd1),
        .rd2_o      (rf_rd2),
        .dbg_o      (dbg_data_o),
        .we_i       (wb_we_q),
        .wa_i       (wb_rd_q),
        .wd_i       (wb_data_q)
    );

    always_comb begin
        op_a    = (wb_we_q && dec.rs1 != 5'd0 && wb_rd_q == dec.rs1) ? wb_data_q : rf_rd1;
        rs2_val = (wb_we_q && dec.rs2 != 5'd0 && wb_rd_q == dec.rs2) ? wb_data_q : rf_rd2;
        op_b    = dec.use_imm ? dec.imm : rs2_val;
        shamt   = op_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (dec.alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            wb_we_q   <= dec.we;
            wb_rd_q   <= dec.we ? dec.rd : 5'd0;
            wb_data_q <= dec.we ? alu_res : '0;
            illegal_q <= dec.illegal;
        end
    end

    assign wb_we_o   = wb_we_q;
    assign wb_rd_o   = wb_rd_q;
    assign wb_data_o = wb_data_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Scoreboard bench: each issued instruction pushes its expected WB outcome,
// which is popped and compared one cycle later when the stage presents it.
module tb_execute_writeback_stage;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execute_writeback_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction_EX (instr),
        .wb_we_o        (wb_we),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .illegal_o      (illegal),
        .dbg_addr_i     (dbg_addr),
        .dbg_data_o     (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Drive one instruction for one cycle, then compare WB against the queued expectation.
    task automatic issue(input string tag, input logic [31:0] inst, input logic we,
                         input logic [4:0] rd, input logic [31:0] data, input logic ill);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.ill = ill; e.tag = tag;
        instr = inst;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".we"},  {31'd0, wb_we},   {31'd0, e.we});
        check({e.tag, ".ill"}, {31'd0, illegal}, {31'd0, e.ill});
        if (e.we) begin
            check({e.tag, ".rd"},   {27'd0, wb_rd}, {27'd0, e.rd});
            check({e.tag, ".data"}, wb_data, e.data);
        end
        instr = 32'h0;
    endtask

    task automatic bubble();
        issue("bubble", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.we",   {31'd0, wb_we},   32'd0);
        check("rst.rd",   {27'd0, wb_rd},   32'd0);
        check("rst.data", wb_data,          32'd0);
        check("rst.ill",  {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        issue("addi_x1_5", 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0);
        bubble();
        dbg_check("dbg_x1_5", 5'd1, 32'd5);

        issue("addi_x1_5b", 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0);
        issue("add_fwd",    32'h00108133, 1'b1, 5'd2, 32'd10, 1'b0);
        issue("addi_x1_7",  32'h00700093, 1'b1, 5'd1, 32'd7, 1'b0);
        bubble();
        issue("add_rf",     32'h00108133, 1'b1, 5'd2, 32'd14, 1'b0);
        bubble();
        dbg_check("dbg_x2_14", 5'd2, 32'd14);

        issue("addi_x0", 32'h00700013, 1'b0, 5'd0, 32'h0, 1'b0);
        bubble();
        dbg_check("dbg_x0", 5'd0, 32'd0);

        issue("lui_x3",   32'hABCDE1B7, 1'b1, 5'd3, 32'hABCDE000, 1'b0);
        issue("srai_x4",  32'h4041D213, 1'b1, 5'd4, 32'hFABCDE00, 1'b0);
        issue("sltu_x5",  32'h003032B3, 1'b1, 5'd5, 32'd1,        1'b0);
        issue("sub_x6",   32'h40308333, 1'b1, 5'd6, 32'h54322007, 1'b0);
        issue("slt_x7",   32'h0011A3B3, 1'b1, 5'd7, 32'd1,        1'b0);
        issue("sltu_x7",  32'h0011B3B3, 1'b1, 5'd7, 32'd0,        1'b0);
        issue("slli_x9",  32'h00309493, 1'b1, 5'd9, 32'h38,       1'b0);
        bubble();
        dbg_check("dbg_x7_last", 5'd7, 32'd0);
        dbg_check("dbg_x4",      5'd4, 32'hFABCDE00);

        issue("ill_ffff",  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1);
        issue("ill_pulse", 32'h0,        1'b0, 5'd0, 32'h0, 1'b0);
        issue("ill_f7",    32'h02108133, 1'b0, 5'd0, 32'h0, 1'b1);
        issue("ill_slli",  32'h40309493, 1'b0, 5'd0, 32'h0, 1'b1);
        bubble();
        dbg_check("dbg_x1_kept", 5'd1, 32'd7);
        dbg_check("dbg_x2_kept", 5'd2, 32'd14);

        // Reset lands while the ADDI result sits in WB: it must be dropped.
        issue("addi_pre_rst", 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst.we",   {31'd0, wb_we},   32'd0);
        check("post_rst.rd",   {27'd0, wb_rd},   32'd0);
        check("post_rst.data", wb_data,          32'd0);
        check("post_rst.ill",  {31'd0, illegal}, 32'd0);
        dbg_check("post_rst_x1", 5'd1, 32'd0);
        bubble();
        dbg_check("post_rst_x1b", 5'd1, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
